wb_stage: RTL

- Writeback end of the fetch/decode/execute pipeline.
- Consumes the 71-bit EX_WB bundle produced by fetchDecExe and performs the data-memory read for loads over a ready/ack handshake.
- Drives the register-file write port, mirrors that write onto a forwarding bus, and counts retired instructions.
- Supplies backpressure to the execute stage through ex_wb_ready.

---
 rtl/fde_pkg.sv | 32 +++
 rtl/wb_load_timer.sv | 30 +++
 rtl/wb_stage.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/fde_pkg.sv
// Shared definitions for the fetch/decode/execute pipeline: EX_WB bundle
// field positions, the default load opcode and the writeback FSM states.
package fde_pkg;

   localparam int EXWB_W    = 71;
   localparam int VALID_BIT = 70;
   localparam int REGW_BIT  = 69;
   localparam int RD_HI     = 68;
   localparam int RD_LO     = 64;
   localparam int RES_HI    = 63;
   localparam int RES_LO    = 32;
   localparam int INSTR_HI  = 31;
   localparam int INSTR_LO  = 0;

   // lw major opcode in instr[31:26]
   localparam logic [5:0] LOAD_OPCODE_DEF = 6'h23;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WRITE    = 2'd1,
      LOAD_REQ = 2'd2,
      LOAD_WB  = 2'd3
   } wb_state_t;

   // The opcode alone decides whether an instruction is a load; no other
   // bundle field can override it.
   function automatic logic is_load(input logic [31:0] instr,
                                    input logic [5:0]  opcode);
      return instr[31:26] == opcode;
   endfunction

endpackage

// File: rtl/wb_load_timer.sv
// Cycle counter for an outstanding data-memory load. The count reads 1 in
// the first request cycle and 'expired' is high in the TIMEOUT-th cycle.
module wb_load_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       advance,
   input  logic       clear,
   output logic [7:0] count,
   output logic       expired
);

   localparam logic [7:0] LIMIT = 8'(TIMEOUT);

   // Clear wins over start, start wins over advance.
   always_ff @(posedge clock) begin
      if (reset || clear) begin
         count <= 8'd0;
      end else if (start) begin
         count <= 8'd1;
      end else if (advance && count != 8'hFF) begin
         count <= count + 8'd1;
      end
   end

   assign expired = (count == LIMIT);

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: latches the EX_WB bundle, performs the data-memory read
// for loads, drives the register-file write port plus its forwarding mirror
// and counts retired instructions.
//
// Handshakes: an EX_WB bundle transfers on a rising edge where EX_WB[70]
// and ex_wb_ready are both high; ex_wb_ready depends only on the FSM state.
// dmem_req is held high until a cycle with dmem_ack high, in which
// dmem_rdata is taken; ack outside an outstanding request is ignored.
module wb_stage
   import fde_pkg::*;
#(
   parameter logic [5:0] LOAD_OPCODE = LOAD_OPCODE_DEF,
   parameter int         TIMEOUT     = 16,
   parameter int         CNT_W       = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [70:0]       EX_WB,
   output logic              ex_wb_ready,
   output logic              dmem_req,
   output logic [31:0]       dmem_addr,
   input  logic              dmem_ack,
   input  logic [31:0]       dmem_rdata,
   output logic              rf_we,
   output logic [4:0]        rf_waddr,
   output logic [31:0]       rf_wdata,
   output logic              fwd_valid,
   output logic [4:0]        fwd_rd,
   output logic [31:0]       fwd_data,
   output logic              load_err,
   output logic [CNT_W-1:0]  retired_count,
   output logic [1:0]        dbg_state
);

   wb_state_t        state;
   wb_state_t        state_nxt;

   logic             entry_regw;
   logic [4:0]       entry_rd;
   logic [31:0]      entry_res;
   logic [31:0]      rdata_q;
   logic             load_err_q;
   logic [CNT_W-1:0] cnt_q;

   logic             accept;
   logic             acc_load;
   logic             ack_take;
   logic             timed_out;
   logic             retire_evt;
   logic             write_now;

   logic [7:0]       timer_count;
   logic             timer_expired;

   assign ex_wb_ready = (state == IDLE) || (state == WRITE);
   assign accept      = EX_WB[VALID_BIT] && ex_wb_ready;
   assign acc_load    = accept && is_load(EX_WB[INSTR_HI:INSTR_LO], LOAD_OPCODE);
   assign ack_take    = (state == LOAD_REQ) && dmem_ack;
   // An ack in the final allowed cycle takes priority over the timeout.
   assign timed_out   = (state == LOAD_REQ) && !dmem_ack && timer_expired;

   // Retirement is counted at the edge that enters the retiring cycle, so
   // the count already includes an instruction while its rf_we is high.
   assign retire_evt  = (accept && !acc_load) || ack_take || timed_out;

   wb_load_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clock   (clock),
      .reset   (reset),
      .start   (acc_load),
      .advance (state == LOAD_REQ),
      .clear   (ack_take || timed_out),
      .count   (timer_count),
      .expired (timer_expired)
   );

   // Next-state selection for the writeback FSM.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, WRITE: begin
            if (accept) begin
               state_nxt = acc_load ? LOAD_REQ : WRITE;
            end else begin
               state_nxt = IDLE;
            end
         end
         LOAD_REQ: begin
            if (ack_take) begin
               state_nxt = LOAD_WB;
            end else if (timed_out) begin
               state_nxt = IDLE;
            end
         end
         LOAD_WB: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register and the latched entry; reset discards any pending load.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         entry_regw <= 1'b0;
         entry_rd   <= 5'd0;
         entry_res  <= 32'd0;
         rdata_q    <= 32'd0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            entry_regw <= EX_WB[REGW_BIT];
            entry_rd   <= EX_WB[RD_HI:RD_LO];
            entry_res  <= EX_WB[RES_HI:RES_LO];
         end
         if (ack_take) begin
            rdata_q <= dmem_rdata;
         end
      end
   end

   // Sticky load-timeout flag and the wrapping retirement counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         load_err_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         if (timed_out) begin
            load_err_q <= 1'b1;
         end
         if (retire_evt) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   // Writes to r0 or without reg_write still retire, they just do not write.
   assign write_now = ((state == WRITE) || (state == LOAD_WB)) &&
                      entry_regw && (entry_rd != 5'd0);

   // Register-file write port, zero whenever no write is happening.
   always_comb begin
      rf_we    = write_now;
      rf_waddr = 5'd0;
      rf_wdata = 32'd0;
      if (write_now) begin
         rf_waddr = entry_rd;
         rf_wdata = (state == LOAD_WB) ? rdata_q : entry_res;
      end
   end

   assign fwd_valid     = rf_we;
   assign fwd_rd        = rf_waddr;
   assign fwd_data      = rf_wdata;

   assign dmem_req      = (state == LOAD_REQ);
   assign dmem_addr     = (state == LOAD_REQ) ? entry_res : 32'd0;
   assign load_err      = load_err_q;
   assign retired_count = cnt_q;
   assign dbg_state     = state;

endmodule
